// File: rtl/load_extend_unit_if.sv
// Request, memory-port and response signals of the load/extend unit.
// The slave modport is the unit's view; the master modport is its environment.
interface load_extend_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  // Request from the execute stage
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic [2:0]            req_funct3;
  logic [4:0]            req_rd;
  // Data-memory read port
  logic                  mem_rd_en;
  logic [31:0]           mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // Response to the pipeline
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [4:0]            rsp_rd;
  logic                  rsp_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd, mem_ack, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err, busy
  );

  modport master (
    output req_valid, req_addr, req_funct3, req_rd, mem_ack, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err, busy
  );
endinterface

// File: rtl/load_extend_unit.sv
// Multi-cycle load controller: one request in flight, word-aligned memory read,
// byte/halfword/word extraction with sign or zero extension, error reporting for
// misaligned, illegal and timed-out loads. Only DATA_WIDTH = 32 is supported.
module load_extend_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  load_extend_unit_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            lane_q, lane_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]            rsp_rd_q, rsp_rd_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  req_bad;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_val;

  assign bus.req_ready = (state_q == StIdle) && rst_n;
  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != StIdle);

  // Classify the incoming request: illegal funct3 or misaligned for its size
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_funct3)
      F3Lb, F3Lbu: req_bad = 1'b0;
      F3Lh, F3Lhu: req_bad = bus.req_addr[0];
      F3Lw:        req_bad = (bus.req_addr[1:0] != 2'b00);
      default:     req_bad = 1'b1;
    endcase
  end

  // Select the addressed lane from the returned word and extend it to 32 bits
  always_comb begin
    byte_sel = 8'h00;
    unique case (lane_q)
      2'd0: byte_sel = bus.mem_rdata[7:0];
      2'd1: byte_sel = bus.mem_rdata[15:8];
      2'd2: byte_sel = bus.mem_rdata[23:16];
      2'd3: byte_sel = bus.mem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_val = '0;
    case (funct3_q)
      F3Lb:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3Lbu:   load_val = {24'h000000, byte_sel};
      F3Lh:    load_val = {{16{half_sel[15]}}, half_sel};
      F3Lhu:   load_val = {16'h0000, half_sel};
      F3Lw:    load_val = bus.mem_rdata;
      default: load_val = '0;
    endcase
  end

  // Next-state and registered-output logic of the IDLE/MEM/RESP controller
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    funct3_d    = funct3_q;
    mem_rd_en_d = mem_rd_en_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          lane_d   = bus.req_addr[1:0];
          funct3_d = bus.req_funct3;
          rsp_rd_d = bus.req_rd;
          if (req_bad) begin
            // Rejected without touching memory
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d     = StMem;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            cnt_d       = '0;
          end
        end
      end
      StMem: begin
        // Ack takes priority over the timeout threshold in the same cycle
        if (bus.mem_ack) begin
          state_d     = StResp;
          mem_rd_en_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = load_val;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d     = StResp;
          mem_rd_en_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lane_q      <= 2'b00;
      funct3_q    <= 3'b000;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      funct3_q    <= funct3_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// Bench for load_extend_unit: directed loads from the test plan, reset during a
// memory access, then randomized loads checked against a behavioural model.
module tb_load_extend_unit;

  localparam int unsigned Timeout = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  load_extend_unit_if #(.DATA_WIDTH(32)) bif ();

  load_extend_unit #(
    .DATA_WIDTH(32),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: {err, value} from the load rules; err covers illegal and misaligned only
  function automatic logic [32:0] ref_load(input logic [31:0] addr, input logic [2:0] f3,
                                           input logic [31:0] data);
    int unsigned size;
    bit          sgn;
    longint      v;
    logic [31:0] r;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      default: return {1'b1, 32'h0};
    endcase
    if ((addr % size) != 0) return {1'b1, 32'h0};
    v = longint'(data >> (8 * (addr % 4)));
    v = v % (longint'(1) << (8 * size));
    if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    r = v[31:0];
    return {1'b0, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bif.req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_wait", {31'b0, bif.req_ready}, 32'd1);
  endtask

  // One load end to end; ack_at = MEM cycle index carrying the ack (<0: never)
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] data, input int ack_at, input int hold);
    logic [32:0] m;
    logic        exp_err;
    logic [31:0] exp_data;
    int          en_cycles;
    int          exp_en;
    bit          acked;
    m = ref_load(addr, f3, data);
    acked = !m[32] && ack_at >= 0 && ack_at < int'(Timeout);
    exp_en = m[32] ? 0 : (acked ? ack_at + 1 : int'(Timeout));
    exp_err = !acked;
    exp_data = exp_err ? 32'h0 : m[31:0];

    wait_ready();
    bif.req_valid  = 1'b1;
    bif.req_addr   = addr;
    bif.req_funct3 = f3;
    bif.req_rd     = rd;
    tick();
    bif.req_valid  = 1'b0;
    bif.req_addr   = $urandom;
    bif.req_funct3 = 3'($urandom);
    bif.req_rd     = 5'($urandom);

    en_cycles = 0;
    for (int i = 0; i < int'(Timeout) + 4 && bif.mem_rd_en; i++) begin
      check("mem_addr", bif.mem_addr, addr & 32'hFFFF_FFFC);
      check("rsp_valid_in_mem", {31'b0, bif.rsp_valid}, 32'd0);
      check("busy_in_mem", {31'b0, bif.busy}, 32'd1);
      bif.mem_ack   = (i == ack_at);
      bif.mem_rdata = (i == ack_at) ? data : $urandom;
      en_cycles++;
      tick();
      bif.mem_ack = 1'b0;
    end
    check("mem_rd_en_cycles", en_cycles, exp_en);
    check("rsp_valid", {31'b0, bif.rsp_valid}, 32'd1);
    check("rsp_data", bif.rsp_data, exp_data);
    check("rsp_err", {31'b0, bif.rsp_err}, {31'b0, exp_err});
    check("rsp_rd", {27'b0, bif.rsp_rd}, {27'b0, rd});

    // Back-pressure: a competing request must be ignored while the response waits
    bif.req_valid  = 1'b1;
    bif.req_addr   = 32'h0000_0300;
    bif.req_funct3 = 3'b010;
    for (int i = 0; i < hold; i++) begin
      bif.mem_ack = 1'b1;
      tick();
      bif.mem_ack = 1'b0;
      check("hold_valid", {31'b0, bif.rsp_valid}, 32'd1);
      check("hold_data", bif.rsp_data, exp_data);
      check("hold_err", {31'b0, bif.rsp_err}, {31'b0, exp_err});
      check("hold_rd", {27'b0, bif.rsp_rd}, {27'b0, rd});
      check("hold_req_ready", {31'b0, bif.req_ready}, 32'd0);
      check("hold_busy", {31'b0, bif.busy}, 32'd1);
      check("hold_mem_rd_en", {31'b0, bif.mem_rd_en}, 32'd0);
    end
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    check("post_hs_valid", {31'b0, bif.rsp_valid}, 32'd0);
    check("post_hs_no_accept", {31'b0, bif.mem_rd_en}, 32'd0);
    check("post_hs_req_ready", {31'b0, bif.req_ready}, 32'd1);
    check("post_hs_busy", {31'b0, bif.busy}, 32'd0);
    bif.req_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bif.req_valid  = 1'b0;
    bif.req_addr   = '0;
    bif.req_funct3 = '0;
    bif.req_rd     = '0;
    bif.mem_ack    = 1'b0;
    bif.mem_rdata  = '0;
    bif.rsp_ready  = 1'b0;
    tick();
    tick();
    check("rst_req_ready", {31'b0, bif.req_ready}, 32'd0);
    check("rst_mem_rd_en", {31'b0, bif.mem_rd_en}, 32'd0);
    check("rst_mem_addr", bif.mem_addr, 32'd0);
    check("rst_rsp_valid", {31'b0, bif.rsp_valid}, 32'd0);
    check("rst_rsp_data", bif.rsp_data, 32'd0);
    check("rst_rsp_rd", {27'b0, bif.rsp_rd}, 32'd0);
    check("rst_rsp_err", {31'b0, bif.rsp_err}, 32'd0);
    check("rst_busy", {31'b0, bif.busy}, 32'd0);
    rst_n = 1'b1;
    #1;

    // Byte, halfword and word extraction from a fixed word
    run_load(32'h100, 3'b000, 5'd1, 32'h8001_7F80, 0, 0);
    run_load(32'h101, 3'b100, 5'd2, 32'h8001_7F80, 0, 0);
    run_load(32'h103, 3'b000, 5'd3, 32'h8001_7F80, 0, 0);
    run_load(32'h102, 3'b001, 5'd4, 32'h8001_7F80, 0, 0);
    run_load(32'h102, 3'b101, 5'd5, 32'h8001_7F80, 0, 0);
    run_load(32'h100, 3'b001, 5'd6, 32'h8001_7F80, 0, 0);
    run_load(32'h100, 3'b010, 5'd7, 32'h8001_7F80, 0, 0);
    // Misaligned and illegal requests
    run_load(32'h103, 3'b001, 5'd8, 32'h8001_7F80, 0, 0);
    run_load(32'h102, 3'b010, 5'd9, 32'h8001_7F80, 0, 0);
    run_load(32'h100, 3'b011, 5'd10, 32'h8001_7F80, 0, 0);
    // Timeout, then ack on the last MEM cycle
    run_load(32'h200, 3'b010, 5'd11, 32'hDEAD_BEEF, -1, 0);
    run_load(32'h200, 3'b010, 5'd12, 32'hDEAD_BEEF, int'(Timeout) - 1, 0);
    // Response back-pressure
    run_load(32'h104, 3'b000, 5'd13, 32'h1234_5678, 1, 3);

    // Reset during MEM, followed by a late ack
    wait_ready();
    bif.req_valid  = 1'b1;
    bif.req_addr   = 32'h400;
    bif.req_funct3 = 3'b010;
    bif.req_rd     = 5'd14;
    tick();
    bif.req_valid = 1'b0;
    check("rstmem_en", {31'b0, bif.mem_rd_en}, 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    check("rstmem_en_off", {31'b0, bif.mem_rd_en}, 32'd0);
    check("rstmem_valid", {31'b0, bif.rsp_valid}, 32'd0);
    check("rstmem_busy", {31'b0, bif.busy}, 32'd0);
    check("rstmem_req_ready", {31'b0, bif.req_ready}, 32'd0);
    rst_n = 1'b1;
    bif.mem_ack = 1'b1;
    bif.mem_rdata = 32'hCAFE_F00D;
    #1;
    check("rstmem_ready_after", {31'b0, bif.req_ready}, 32'd1);
    tick();
    bif.mem_ack = 1'b0;
    check("late_ack_valid", {31'b0, bif.rsp_valid}, 32'd0);
    check("late_ack_busy", {31'b0, bif.busy}, 32'd0);
    run_load(32'h404, 3'b010, 5'd15, 32'h0BAD_CAFE, 2, 1);

    // Randomized loads against the model
    for (int n = 0; n < 40; n++) begin
      run_load($urandom, 3'($urandom_range(0, 7)), 5'($urandom), $urandom,
               int'($urandom_range(0, 6)) - 1, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_extend_unit.md
# load_extend_unit

Multi-cycle load controller between the execute stage and the data-memory port. Accepts one load request at a time and issues a word-aligned memory read. Extracts the addressed byte, halfword or word from the returned data and sign- or zero-extends it to 32 bits per funct3. Returns the result with the destination register index. Misaligned accesses, illegal funct3 codes and memory timeouts are reported without corrupting state.

## Interface
- DATA_WIDTH, 32: memory and result width; only 32 is supported.
- TIMEOUT, 255: maximum cycles spent waiting for mem_ack before an error response; must be ≥1; counter width is clog2(TIMEOUT+1).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  32  byte address.
- req_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
- req_rd  in  5  destination register index, passed through.
- mem_rd_en  out  1  memory read strobe, held until ack.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_ack  in  1  read data valid on mem_rdata.
- mem_rdata  in  32  read data, little-endian lanes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  extended load result; 0 when rsp_err=1.
- rsp_rd  out  5  captured req_rd.
- rsp_err  out  1  misaligned, illegal funct3, or timeout.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, MEM, RESP.
- Reset: all registered outputs are cleared (mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err, busy = 0), the timeout counter is cleared, and state = IDLE. req_ready = (state==IDLE) && rst_n, so no request is accepted while rst_n=0.
- IDLE: on req_valid && req_ready, capture addr, funct3 and rd.
  - Illegal funct3, LH/LHU with addr[0]=1, or LW with addr[1:0]≠0: go to RESP with rsp_err=1 and rsp_data=0. No memory access is made.
  - Otherwise: go to MEM with mem_rd_en=1, mem_addr aligned, and counter=0.
- MEM: mem_rd_en stays 1 and mem_addr stays stable.
  - mem_ack=1: register the extracted and extended data, set rsp_err=0, drop mem_rd_en, go to RESP.
  - No ack: increment the counter. When counter reaches TIMEOUT-1 with no ack, drop mem_rd_en, set rsp_err=1 and rsp_data=0, go to RESP.
  - Ack on the same cycle as the timeout threshold: ack wins.
- Extraction:
  - Byte lane = addr[1:0], byte k = mem_rdata[8k+7:8k].
  - Half lane = addr[1], halfword h = mem_rdata[16h+15:16h].
  - LB/LH replicate the MSB into the upper bits; LBU/LHU zero-fill; LW passes the word unchanged.
- RESP: rsp_valid=1 and rsp_data, rsp_rd, rsp_err are held stable. On rsp_ready=1, clear rsp_valid and go to IDLE.
- mem_ack outside MEM is ignored.
- rst_n=0 in any state: the next edge forces the reset values and discards the in-flight request. An ack arriving after that is ignored.

## Timing
- Accept at edge N → mem_rd_en=1 from cycle N+1.
- Ack sampled at edge N+k (k≥1) → rsp_valid=1 from cycle N+k+1. Minimum load latency is 2 cycles, accept to rsp_valid.
- Error on request (misaligned or illegal): rsp_valid=1 from cycle N+1.
- Timeout: rsp_valid rises TIMEOUT+1 cycles after accept.
- Response handshake at edge M → req_ready=1 from cycle M+1. No back-to-back overlap; at most one request is in flight.
- mem_rd_en is asserted for exactly the MEM cycles, and never in the same cycle as rsp_valid.

## Test plan
- mem_rdata=0x80017F80, ack 1 cycle after mem_rd_en. Expected responses:
  - LB @0x100 → 0xFFFFFF80.
  - LBU @0x101 → 0x0000007F.
  - LB @0x103 → 0xFFFFFF80.
  - All with rsp_err=0, mem_addr=0x100, rsp_rd echoed.
- Same data, halfword and word loads:
  - LH @0x102 → 0xFFFF8001.
  - LHU @0x102 → 0x00008001.
  - LH @0x100 → 0x00007F80.
  - LW @0x100 → 0x80017F80.
- LH @0x103, LW @0x102, funct3=011 → rsp_err=1, rsp_data=0, rsp_valid one cycle after accept, mem_rd_en never asserted.
- TIMEOUT=4, mem_ack held 0 → mem_rd_en high exactly 4 cycles, then rsp_err=1 and rsp_data=0. Repeat with ack on the 4th MEM cycle → valid data, rsp_err=0.
- rsp_ready held 0 for 3 cycles → rsp_* stable, req_ready=0, busy=1. A new req_valid is not accepted until the cycle after the handshake.
- rst_n=0 for one cycle during MEM, followed by a late mem_ack → mem_rd_en=0 and state IDLE after the edge, no rsp_valid, req_ready=1 once rst_n=1, and the next LW completes normally.
